// File: rtl/bcd_display_pkg.sv
// Shared constants, FSM state encoding and reset-pattern helper for the BCD
// seven-segment display driver (active-low segments, bit order gfedcba).
package bcd_display_pkg;

    localparam int unsigned NIBBLE_BITS = 4;
    localparam int unsigned SEG_BITS    = 7;
    localparam int unsigned MAX_DIGITS  = 16;

    localparam logic [SEG_BITS-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_BITS-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_BITS-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_BITS-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_BITS-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_BITS-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_BITS-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_BITS-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_BITS-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_BITS-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_BITS-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_BITS-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    // Display pattern of the value 0: digit 0 shows "0", upper digits are
    // blank or "0". Sized for the largest supported display; callers truncate.
    function automatic logic [SEG_BITS*MAX_DIGITS-1:0] reset_pattern(
        input int unsigned digits,
        input bit          blank
    );
        logic [SEG_BITS*MAX_DIGITS-1:0] pat;
        pat = '1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i == 0) begin
                pat[SEG_BITS*i +: SEG_BITS] = SEG_0;
            end else if (i < digits && !blank) begin
                pat[SEG_BITS*i +: SEG_BITS] = SEG_0;
            end else begin
                pat[SEG_BITS*i +: SEG_BITS] = SEG_BLANK;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/bcd_display_if.sv
// Display bus: packed BCD count and enable toward the driver, busy flag and
// active-low segment fields back.
//   countValue    : packed BCD, digit i at [4i+3:4i]
//   displayEnable : 1 = show committed value, 0 = all segments off
//   busy          : conversion of a snapshot in progress
//   segments      : active-low gfedcba, digit i at [7i+6:7i]
interface bcd_display_if #(
    parameter int unsigned DISPLAY_DIGITS = 6,
    parameter int unsigned COUNT_BITWIDTH = 4*DISPLAY_DIGITS
);
    logic [COUNT_BITWIDTH-1:0]   countValue;
    logic                        displayEnable;
    logic                        busy;
    logic [7*DISPLAY_DIGITS-1:0] segments;

    modport master (
        output countValue,
        output displayEnable,
        input  busy,
        input  segments
    );

    modport slave (
        input  countValue,
        input  displayEnable,
        output busy,
        output segments
    );
endinterface

// File: rtl/bcd_display_driver_bcd_to_seven_seg.sv
// Combinational BCD nibble to active-low seven-segment code; any nibble above
// 9 maps to a dash.
//   nibble_i : 4-bit BCD digit
//   seg_o    : active-low gfedcba code
module bcd_to_seven_seg
    import bcd_display_pkg::*;
(
    input  logic [NIBBLE_BITS-1:0] nibble_i,
    output logic [SEG_BITS-1:0]    seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Seven-segment driver for a packed BCD count. A change on the input is
// snapshotted, converted one digit per clock (MSD first) with optional
// leading-zero blanking, then committed atomically to the display.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : slave side of bcd_display_if (countValue, displayEnable in;
//                  busy, segments out)
module bcd_display_driver
    import bcd_display_pkg::*;
#(
    parameter int unsigned DISPLAY_DIGITS      = 6,
    parameter int unsigned COUNT_BITWIDTH      = 4*DISPLAY_DIGITS,
    parameter bit          BLANK_LEADING_ZEROS = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    bcd_display_if.slave  bus
);

    localparam int unsigned TOTAL_SEG_W = SEG_BITS*DISPLAY_DIGITS;
    localparam int unsigned IDX_W       = (DISPLAY_DIGITS > 1) ? $clog2(DISPLAY_DIGITS) : 1;
    localparam logic [TOTAL_SEG_W-1:0] RESET_PATTERN =
        TOTAL_SEG_W'(reset_pattern(DISPLAY_DIGITS, BLANK_LEADING_ZEROS));

    state_e                    state_q, state_d;
    logic [COUNT_BITWIDTH-1:0] last_q, last_d;
    logic [COUNT_BITWIDTH-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      leading_q, leading_d;
    logic                      busy_q, busy_d;
    logic [TOTAL_SEG_W-1:0]    work_q, work_d;
    logic [TOTAL_SEG_W-1:0]    committed_q, committed_d;
    logic [TOTAL_SEG_W-1:0]    segments_q, segments_d;

    logic [NIBBLE_BITS-1:0]    nibble;
    logic [SEG_BITS-1:0]       dec_seg;

    assign nibble = shadow_q[NIBBLE_BITS*idx_q +: NIBBLE_BITS];

    bcd_to_seven_seg u_dec (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= '0;
            shadow_q    <= '0;
            idx_q       <= '0;
            leading_q   <= 1'b0;
            busy_q      <= 1'b0;
            work_q      <= '0;
            committed_q <= RESET_PATTERN;
            segments_q  <= '1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            shadow_q    <= shadow_d;
            idx_q       <= idx_d;
            leading_q   <= leading_d;
            busy_q      <= busy_d;
            work_q      <= work_d;
            committed_q <= committed_d;
            segments_q  <= segments_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        shadow_d    = shadow_q;
        idx_d       = idx_q;
        leading_d   = leading_q;
        busy_d      = busy_q;
        work_d      = work_q;
        committed_d = committed_q;
        // Display follows the previously committed value, one edge behind.
        segments_d  = bus.displayEnable ? committed_q : '1;

        case (state_q)
            ST_IDLE: begin
                if (bus.countValue != last_q) begin
                    shadow_d  = bus.countValue;
                    last_d    = bus.countValue;
                    idx_d     = IDX_W'(DISPLAY_DIGITS - 1);
                    leading_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                // An invalid nibble counts as significant, ending the blank run.
                if (nibble > 4'd9) begin
                    work_d[SEG_BITS*idx_q +: SEG_BITS] = SEG_DASH;
                    leading_d = 1'b0;
                end else if (leading_q && (nibble == 4'd0) && (idx_q != '0)
                             && BLANK_LEADING_ZEROS) begin
                    work_d[SEG_BITS*idx_q +: SEG_BITS] = SEG_BLANK;
                end else begin
                    work_d[SEG_BITS*idx_q +: SEG_BITS] = dec_seg;
                    leading_d = 1'b0;
                end

                if (idx_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end

            ST_COMMIT: begin
                committed_d = work_q;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.segments = segments_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: two instances (blanking on/off) share the same
// stimulus; a monitor checks every committed display against a queue of
// expected patterns produced by a digit-level reference model.
module tb_bcd_display_driver;

    localparam int unsigned DIGITS = 6;
    localparam int unsigned CW     = 4*DIGITS;
    localparam int unsigned SW     = 7*DIGITS;
    localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        logic [SW-1:0] seg_a;
        logic [SW-1:0] seg_b;
        int            cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    logic [CW-1:0] last_val;

    bcd_display_if #(.DISPLAY_DIGITS(DIGITS)) bus_a ();
    bcd_display_if #(.DISPLAY_DIGITS(DIGITS)) bus_b ();

    assign bus_b.countValue    = bus_a.countValue;
    assign bus_b.displayEnable = bus_a.displayEnable;

    bcd_display_driver #(.DISPLAY_DIGITS(DIGITS), .BLANK_LEADING_ZEROS(1'b1)) u_dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    bcd_display_driver #(.DISPLAY_DIGITS(DIGITS), .BLANK_LEADING_ZEROS(1'b0)) u_dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc++;

    // Display of a value: digits above the first nonzero/invalid digit are
    // blank when blanking is on; digit 0 always shows.
    function automatic logic [SW-1:0] ref_display(input logic [CW-1:0] v, input bit blank);
        logic [SW-1:0] r;
        logic [3:0]    d;
        bit            seen;
        r    = '1;
        seen = 1'b0;
        for (int i = DIGITS-1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d != 4'd0 || i == 0) seen = 1'b1;
            if (!seen && blank)  r[7*i +: 7] = 7'h7F;
            else if (d > 4'd9)   r[7*i +: 7] = 7'h3F;
            else                 r[7*i +: 7] = SEG_TBL[d];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a new value at a falling edge and queue what it should display.
    task automatic drive_value(input logic [CW-1:0] v, output int k);
        exp_t e;
        @(negedge clock);
        bus_a.countValue = v;
        k = cyc;
        if (v != last_val) begin
            e.seg_a = ref_display(v, 1'b1);
            e.seg_b = ref_display(v, 1'b0);
            e.cyc   = k + 9;
            sb.push_back(e);
            last_val = v;
        end
    endtask

    // Monitor: after each commit (busy falling outside reset) the next falling
    // edge must show the expected pattern at the expected cycle.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && prev_busy && !bus_a.busy) begin
                @(negedge clock);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got %h expected none", bus_a.segments);
                end else begin
                    e = sb.pop_front();
                    check("commit_seg_blank", 64'(bus_a.segments), 64'(e.seg_a));
                    check("commit_seg_noblank", 64'(bus_b.segments), 64'(e.seg_b));
                    check("commit_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_busy = bus_a.busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int busy_cnt;
        logic [CW-1:0] v;
        logic [SW-1:0] seg_one;
        int nd;

        n_tests  = 0;
        n_fail   = 0;
        last_val = '0;
        reset    = 1'b1;
        bus_a.countValue    = '0;
        bus_a.displayEnable = 1'b1;

        // Reset behaviour
        repeat (3) @(negedge clock);
        check("reset_segments", 64'(bus_a.segments), 64'({SW{1'b1}}));
        check("reset_busy", 64'(bus_a.busy), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_blank", 64'(bus_a.segments), 64'({{5{7'h7F}}, 7'h40}));
        check("post_reset_noblank", 64'(bus_b.segments), 64'({6{7'h40}}));
        busy_cnt = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus_a.busy) busy_cnt++;
        end
        check("idle_busy_never", 64'(busy_cnt), 64'd0);

        // 0 -> 42: busy width and display
        drive_value(24'h000042, k);
        busy_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (bus_a.busy) busy_cnt++;
        end
        check("busy_cycles", 64'(busy_cnt), 64'd7);

        // Maximum value and wrap
        drive_value(24'h999999, k);
        repeat (10) @(negedge clock);
        drive_value(24'h000000, k);
        repeat (10) @(negedge clock);

        // Invalid nibble
        drive_value(24'h00A105, k);
        repeat (10) @(negedge clock);

        // Change during conversion
        drive_value(24'h000001, k);
        repeat (10) @(negedge clock);
        seg_one = ref_display(24'h000001, 1'b1);
        drive_value(24'h000002, k);
        @(negedge clock);
        @(negedge clock);
        bus_a.countValue = 24'h000003;
        begin
            exp_t e;
            e.seg_a = ref_display(24'h000003, 1'b1);
            e.seg_b = ref_display(24'h000003, 1'b0);
            e.cyc   = k + 17;
            sb.push_back(e);
            last_val = 24'h000003;
        end
        busy_cnt = 0;
        while (cyc < k + 9) begin
            if (bus_a.segments !== seg_one) busy_cnt++;
            @(negedge clock);
        end
        check("hold_old_display", 64'(busy_cnt), 64'd0);
        repeat (12) @(negedge clock);

        // Randomized values, some with short digit counts or invalid nibbles
        for (int t = 0; t < 24; t++) begin
            v  = '0;
            nd = $urandom_range(1, DIGITS);
            for (int i = 0; i < nd; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            drive_value(v, k);
            repeat (10) @(negedge clock);
        end

        // displayEnable low mid-conversion, then reset at CONVERT idx=3
        drive_value(24'h123456, k);
        repeat (10) @(negedge clock);
        @(negedge clock);
        bus_a.countValue = 24'h654321;
        k = cyc;
        @(negedge clock);
        bus_a.displayEnable = 1'b0;
        @(negedge clock);
        check("disable_blank_a", 64'(bus_a.segments), 64'({SW{1'b1}}));
        check("disable_blank_b", 64'(bus_b.segments), 64'({SW{1'b1}}));
        check("disable_still_busy", 64'(bus_a.busy), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        bus_a.countValue = '0;
        @(negedge clock);
        check("midreset_busy", 64'(bus_a.busy), 64'd0);
        check("midreset_segments", 64'(bus_a.segments), 64'({SW{1'b1}}));
        reset = 1'b0;
        bus_a.displayEnable = 1'b1;
        last_val = '0;
        @(negedge clock);
        check("reenable_blank", 64'(bus_a.segments), 64'({{5{7'h7F}}, 7'h40}));
        check("reenable_noblank", 64'(bus_b.segments), 64'({6{7'h40}}));
        busy_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus_a.busy) busy_cnt++;
        end
        check("after_reset_idle", 64'(busy_cnt), 64'd0);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
